ad9361_spi_slave: RTL and testbench
===================================

// Module: ad9361_spi_slave
// PURPOSE
//  SPI responder for the 24-bit AD9361 register frame: {W/Rn, NB[2:0], 2'b00, ADDR[9:0], DATA[7:0]...}.
//  Oversamples SCLK/CSN/SDI in clk, decodes command, drives a local register-file port, shifts read data on SDO.
//  Sits opposite our AD9361 SPI master: bench model of the transceiver and FPGA-side register emulation.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer depth on spi_clk/spi_csn/spi_sdi (>=2)
//  ADDR_INC     0  multi-byte address step: 0 = decrement (AD9361 MSB-first), 1 = increment
// PORTS
//  clk         in   1   system clock; must be >= 8x spi_clk
//  rst_n       in   1   reset, asynchronous, active-low
//  spi_clk     in   1   SCLK from master, CPOL=0, CPHA=0
//  spi_csn     in   1   chip select, active-low
//  spi_sdi     in   1   MOSI (master's SDO)
//  spi_sdo     out  1   MISO
//  spi_sdo_oe  out  1   MISO output enable (high only during read data phase)
//  reg_wr      out  1   1-cycle write strobe
//  reg_rd      out  1   1-cycle read strobe
//  reg_addr    out  10  register address, valid with reg_wr/reg_rd
//  reg_wdata   out  8   write data, valid with reg_wr
//  reg_rdata   in   8   read data, sampled exactly 1 clk after reg_rd
//  frame_done  out  1   1-cycle pulse on CSN rise after a complete frame
//  frame_err   out  1   1-cycle pulse on CSN rise after a malformed/aborted frame
// BEHAVIOUR
//  Reset: all outputs 0 except spi_sdo_oe=0, spi_sdo=0; FSM=WAIT_IDLE.
//  Inputs pass SYNC_STAGES flops; rise/fall/CSN edges detected on synced copies; SDI sampled with same delay.
//  FSM: WAIT_IDLE -> IDLE when synced CSN=1 (so reset mid-frame never decodes a partial frame).
//   IDLE -> CMD on CSN fall; bit_cnt=0, shifter cleared.
//   CMD: shift SDI MSB-first on each SCLK rise; after 16th bit latch wr_rdn=b23, nb=b22:20+1, addr=b17:8.
//    Bits 19:18 ignored. Write -> WDATA; read -> issue reg_rd next clk with reg_addr=addr, go RDATA.
//   WDATA: shift 8 bits per byte; after 8th rise pulse reg_wr next clk (addr, byte); step addr (ADDR_INC);
//    byte_cnt++; if byte_cnt==nb -> TAIL.
//   RDATA: capture reg_rdata 1 clk after reg_rd into sdo shifter; spi_sdo_oe=1; spi_sdo=bit7 before 1st data fall
//    edge, then next bit on each SCLK fall; after 8th rise of byte: step addr, reg_rd for next byte
//    (if byte_cnt<nb) else TAIL.
//   TAIL: extra SCLK edges ignored, no strobes, spi_sdo=0, oe=0; sets overrun flag.
//  CSN rise in any non-idle state -> IDLE next clk; spi_sdo_oe=0, spi_sdo=0.
//   frame_done if all nb bytes completed and no overrun; else frame_err (partial byte, missing bytes,
//   extra bits, CSN rise during CMD).
//  Completed bytes before an abort keep their reg_wr; a partial byte never produces reg_wr.
//  reg_wr and reg_rd never asserted in the same cycle; addr wraps modulo 1024 (0x000-1 -> 0x3FF).
//  CSN fall while FSM busy (no rise seen) impossible by construction; CSN glitch shorter than sync ignored.
//  Bit counter 5 bits for command, 3 bits within byte; byte counter 4 bits (nb max 8).
// TESTING
//  1. Write frame 0x00A53C (W=1,nb=1,addr 0x0A5... with b23=1: 0x80A53C) -> one reg_wr addr 0x0A5 data 0x3C; frame_done.
//  2. Read 0x003700, reg_rdata=0x5A -> reg_rd addr 0x037; SDO bits 0,1,0,1,1,0,1,0; oe only over 8 bits; frame_done.
//  3. Write nb=3 (0xA010) data 11,22,33 -> reg_wr 0x010/0x11, 0x00F/0x22, 0x00E/0x33; ADDR_INC=1 -> 0x010,0x011,0x012.
//  4. Write aborted after 20 bits -> no reg_wr, frame_err; 32-bit single-byte write -> one reg_wr, frame_err.
//  5. rst_n pulse at bit 10 with CSN low -> outputs 0; rest of frame ignored; next full frame decoded normally.
//  6. Back-to-back frames, 1 clk CSN high, clk=8x SCLK, random addr/data -> every strobe matches scoreboard.

Source files
------------

// File: rtl/ad9361_spi_slave.sv
// rtl/ad9361_spi_slave.sv - AD9361-style 24-bit SPI responder driving a local register-file port
// SCLK/CSN/SDI are oversampled in clk; all framing decisions come from edges of the synced copies.
module ad9361_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_INC    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_csn,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic       spi_sdo_oe,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [9:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_CMD       = 3'd2;
  localparam logic [2:0] S_WDATA     = 3'd3;
  localparam logic [2:0] S_RDATA     = 3'd4;
  localparam logic [2:0] S_TAIL      = 3'd5;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync;
  logic                   sclk_d, csn_d;
  logic                   sclk_s, csn_s, sdi_s;
  logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;

  logic [2:0]  state;
  logic [4:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [3:0]  nb;
  logic [9:0]  addr;
  logic [9:0]  addr_step;
  logic [14:0] shreg;
  logic [7:0]  sdo_sh;
  logic        overrun;
  logic        rd_q;

  // CSN synchronizer resets low so a reset taken mid-frame waits for a real CSN high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      csn_sync  <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      sclk_d    <= sclk_s;
      csn_d     <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_rise  = csn_s & ~csn_d;
  assign csn_fall  = ~csn_s & csn_d;

  assign addr_step  = (ADDR_INC != 0) ? addr + 10'd1 : addr - 10'd1;
  assign spi_sdo_oe = (state == S_RDATA);
  assign spi_sdo    = spi_sdo_oe & sdo_sh[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT_IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      nb         <= '0;
      addr       <= '0;
      shreg      <= '0;
      sdo_sh     <= '0;
      overrun    <= 1'b0;
      rd_q       <= 1'b0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      rd_q       <= reg_rd;
      case (state)
        S_WAIT_IDLE: begin
          if (csn_s) state <= S_IDLE;
        end
        S_IDLE: begin
          if (csn_fall) begin
            state    <= S_CMD;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            overrun  <= 1'b0;
          end
        end
        default: begin
          if (csn_rise) begin
            state      <= S_IDLE;
            frame_done <= (state == S_TAIL) && !overrun;
            frame_err  <= (state != S_TAIL) || overrun;
          end else begin
            case (state)
              S_CMD: begin
                if (sclk_rise) begin
                  shreg   <= {shreg[13:0], sdi_s};
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd15) begin
                    bit_cnt <= '0;
                    nb      <= {1'b0, shreg[13:11]} + 4'd1;
                    addr    <= {shreg[8:0], sdi_s};
                    if (shreg[14]) begin
                      state <= S_WDATA;
                    end else begin
                      state    <= S_RDATA;
                      reg_rd   <= 1'b1;
                      reg_addr <= {shreg[8:0], sdi_s};
                      sdo_sh   <= '0;
                    end
                  end
                end
              end
              S_WDATA: begin
                if (sclk_rise) begin
                  shreg   <= {shreg[13:0], sdi_s};
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt[2:0] == 3'd7) begin
                    bit_cnt   <= '0;
                    reg_wr    <= 1'b1;
                    reg_addr  <= addr;
                    reg_wdata <= {shreg[6:0], sdi_s};
                    addr      <= addr_step;
                    byte_cnt  <= byte_cnt + 4'd1;
                    if (byte_cnt + 4'd1 == nb) state <= S_TAIL;
                  end
                end
              end
              S_RDATA: begin
                // The fall just after a byte boundary must not shift: bit7 of the next byte is still pending.
                if (sclk_fall && bit_cnt[2:0] != 3'd0) sdo_sh <= {sdo_sh[6:0], 1'b0};
                if (sclk_rise) begin
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt[2:0] == 3'd7) begin
                    bit_cnt  <= '0;
                    byte_cnt <= byte_cnt + 4'd1;
                    addr     <= addr_step;
                    if (byte_cnt + 4'd1 < nb) begin
                      reg_rd   <= 1'b1;
                      reg_addr <= addr_step;
                    end else begin
                      state <= S_TAIL;
                    end
                  end
                end
              end
              S_TAIL: begin
                if (sclk_rise) overrun <= 1'b1;
              end
              default: state <= S_WAIT_IDLE;
            endcase
          end
        end
      endcase
      if (rd_q) sdo_sh <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_ad9361_spi_slave.sv
// tb/tb_ad9361_spi_slave.sv - table-driven bench for ad9361_spi_slave
// Two instances (address decrement and increment) share the SPI master stimulus.
module tb_ad9361_spi_slave;

  typedef struct packed {
    logic       wr;
    logic [9:0] addr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [63:0] bits;
    int          nbits;
    int          n_ev;
    ev_t         ev0;
    int          done;
    int          err;
    logic [63:0] rx;
    logic [63:0] oe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_sdi = 1'b0;
  logic       d_sdo, d_oe, d_wr, d_rd, d_done, d_err;
  logic [9:0] d_addr;
  logic [7:0] d_wdata, d_rdata;
  logic       i_sdo, i_oe, i_wr, i_rd, i_done, i_err;
  logic [9:0] i_addr;
  logic [7:0] i_wdata, i_rdata;

  logic [7:0]  mem [1024];
  ev_t         d_log[$];
  ev_t         i_log[$];
  ev_t         exp_q[$];
  int          d_done_cnt = 0, d_err_cnt = 0, overlap = 0;
  int          total = 0, bad = 0;
  logic [63:0] rx_bits, oe_bits;
  vec_t        vecs[9];

  always #5 clk = ~clk;

  ad9361_spi_slave #(.SYNC_STAGES(2), .ADDR_INC(0)) u_dec (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_sdi(spi_sdi),
    .spi_sdo(d_sdo), .spi_sdo_oe(d_oe), .reg_wr(d_wr), .reg_rd(d_rd), .reg_addr(d_addr),
    .reg_wdata(d_wdata), .reg_rdata(d_rdata), .frame_done(d_done), .frame_err(d_err)
  );

  ad9361_spi_slave #(.SYNC_STAGES(2), .ADDR_INC(1)) u_inc (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_sdi(spi_sdi),
    .spi_sdo(i_sdo), .spi_sdo_oe(i_oe), .reg_wr(i_wr), .reg_rd(i_rd), .reg_addr(i_addr),
    .reg_wdata(i_wdata), .reg_rdata(i_rdata), .frame_done(i_done), .frame_err(i_err)
  );

  // Register file with one cycle of read latency.
  always_ff @(posedge clk) begin
    if (d_rd) d_rdata <= mem[d_addr];
    if (i_rd) i_rdata <= mem[i_addr];
  end

  always @(negedge clk) begin
    if (d_wr) d_log.push_back({1'b1, d_addr, d_wdata});
    if (d_rd) d_log.push_back({1'b0, d_addr, 8'h00});
    if (i_wr) i_log.push_back({1'b1, i_addr, i_wdata});
    if (i_rd) i_log.push_back({1'b0, i_addr, 8'h00});
    if (d_done) d_done_cnt++;
    if (d_err) d_err_cnt++;
    if ((d_wr && d_rd) || (i_wr && i_rd)) overlap++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] b, input int n, input int nev, input ev_t e,
                              input int dn, input int er, input logic [63:0] rx, input logic [63:0] oe);
    vec_t v;
    v.bits = b; v.nbits = n; v.n_ev = nev; v.ev0 = e;
    v.done = dn; v.err = er; v.rx = rx; v.oe = oe;
    return v;
  endfunction

  // SCLK period is 8 clk; SDI changes with SCLK fall, SDO is taken at SCLK rise.
  task automatic send_frame(input logic [63:0] bits, input int nbits, input int rst_at, input int gap);
    rx_bits = '0;
    oe_bits = '0;
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mid_frame_outputs",
            {d_wr, d_rd, d_sdo, d_oe, d_done, d_err, d_addr, d_wdata}, 64'h0);
        rst_n = 1'b1;
      end
      spi_sdi = bits[63-i];
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      rx_bits = {rx_bits[62:0], d_sdo};
      oe_bits = {oe_bits[62:0], d_oe};
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_csn = 1'b1;
    spi_sdi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int d0, e0, nb, rxp;
    logic        wr;
    logic [9:0]  a;
    logic [63:0] f, exp_rx;
    logic [7:0]  db;

    for (int k = 0; k < 1024; k++) mem[k] = 8'($urandom);
    mem[10'h037] = 8'h5A;
    mem[10'h012] = 8'hC3;
    mem[10'h000] = 8'h81;
    mem[10'h3FF] = 8'h7E;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {d_wr, d_rd, d_sdo, d_oe, d_done, d_err, d_addr, d_wdata}, 64'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_no_pulses", {32'(d_done_cnt), 32'(d_err_cnt)}, 64'h0);

    vecs[0] = mk({24'h80A53C, 40'h0}, 24, 1, {1'b1, 10'h0A5, 8'h3C}, 1, 0, 64'h0, 64'h0);
    vecs[1] = mk({24'h003700, 40'h0}, 24, 1, {1'b0, 10'h037, 8'h00}, 1, 0, 64'h5A, 64'hFF);
    vecs[2] = mk({24'h80A53C, 40'h0}, 20, 0, '0, 0, 1, 64'h0, 64'h0);
    vecs[3] = mk({32'h80123CFF, 32'h0}, 32, 1, {1'b1, 10'h012, 8'h3C}, 0, 1, 64'h0, 64'h0);
    vecs[4] = mk({24'h80A53C, 40'h0}, 10, 0, '0, 0, 1, 64'h0, 64'h0);
    vecs[5] = mk({32'h00120000, 32'h0}, 32, 1, {1'b0, 10'h012, 8'h00}, 0, 1, 64'hC300, 64'hFF00);
    vecs[6] = mk({24'h83FFFF, 40'h0}, 24, 1, {1'b1, 10'h3FF, 8'hFF}, 1, 0, 64'h0, 64'h0);
    vecs[7] = mk({24'h8C0155, 40'h0}, 24, 1, {1'b1, 10'h001, 8'h55}, 1, 0, 64'h0, 64'h0);
    vecs[8] = mk({24'h003700, 40'h0}, 20, 1, {1'b0, 10'h037, 8'h00}, 0, 1, 64'h5, 64'hF);

    for (int v = 0; v < 9; v++) begin
      d_log.delete();
      d0 = d_done_cnt;
      e0 = d_err_cnt;
      send_frame(vecs[v].bits, vecs[v].nbits, -1, 8);
      chk($sformatf("v%0d_n_ev", v), 64'(d_log.size()), 64'(vecs[v].n_ev));
      if (d_log.size() > 0) chk($sformatf("v%0d_ev0", v), 64'(d_log[0]), 64'(vecs[v].ev0));
      chk($sformatf("v%0d_done", v), 64'(d_done_cnt - d0), 64'(vecs[v].done));
      chk($sformatf("v%0d_err", v), 64'(d_err_cnt - e0), 64'(vecs[v].err));
      chk($sformatf("v%0d_sdo", v), rx_bits, vecs[v].rx);
      chk($sformatf("v%0d_oe", v), oe_bits, vecs[v].oe);
      chk($sformatf("v%0d_oe_after", v), {63'h0, d_oe}, 64'h0);
    end

    // Three-byte write: decrementing and incrementing address steps.
    d_log.delete();
    i_log.delete();
    d0 = d_done_cnt;
    send_frame({40'hA010112233, 24'h0}, 40, -1, 8);
    chk("mb_wr_n", 64'(d_log.size()), 64'd3);
    chk("mb_wr_inc_n", 64'(i_log.size()), 64'd3);
    if (d_log.size() == 3) begin
      chk("mb_wr_dec0", 64'(d_log[0]), 64'({1'b1, 10'h010, 8'h11}));
      chk("mb_wr_dec1", 64'(d_log[1]), 64'({1'b1, 10'h00F, 8'h22}));
      chk("mb_wr_dec2", 64'(d_log[2]), 64'({1'b1, 10'h00E, 8'h33}));
    end
    if (i_log.size() == 3) begin
      chk("mb_wr_inc0", 64'(i_log[0]), 64'({1'b1, 10'h010, 8'h11}));
      chk("mb_wr_inc1", 64'(i_log[1]), 64'({1'b1, 10'h011, 8'h22}));
      chk("mb_wr_inc2", 64'(i_log[2]), 64'({1'b1, 10'h012, 8'h33}));
    end
    chk("mb_wr_done", 64'(d_done_cnt - d0), 64'd1);

    // Two-byte read from address 0: decrement wraps to 0x3FF.
    d_log.delete();
    i_log.delete();
    send_frame({32'h10000000, 32'h0}, 32, -1, 8);
    chk("mb_rd_n", 64'(d_log.size()), 64'd2);
    if (d_log.size() == 2) chk("mb_rd_wrap", 64'(d_log[1]), 64'({1'b0, 10'h3FF, 8'h00}));
    if (i_log.size() == 2) chk("mb_rd_inc", 64'(i_log[1]), 64'({1'b0, 10'h001, 8'h00}));
    chk("mb_rd_sdo", rx_bits, 64'h817E);
    chk("mb_rd_oe", oe_bits, 64'hFFFF);

    // Reset taken at bit 10 with CSN low: the remainder of that frame is discarded.
    d_log.delete();
    d0 = d_done_cnt;
    e0 = d_err_cnt;
    send_frame({24'h80A53C, 40'h0}, 24, 10, 8);
    chk("rst_frame_n_ev", 64'(d_log.size()), 64'd0);
    chk("rst_frame_pulses", {32'(d_done_cnt - d0), 32'(d_err_cnt - e0)}, 64'h0);
    send_frame({24'h80A53C, 40'h0}, 24, -1, 8);
    chk("post_rst_n_ev", 64'(d_log.size()), 64'd1);
    if (d_log.size() > 0) chk("post_rst_ev", 64'(d_log[0]), 64'({1'b1, 10'h0A5, 8'h3C}));
    chk("post_rst_done", 64'(d_done_cnt - d0), 64'd1);

    // Back-to-back random frames separated by a single clk of CSN high.
    d_log.delete();
    exp_q.delete();
    d0 = d_done_cnt;
    e0 = d_err_cnt;
    for (int fr = 0; fr < 20; fr++) begin
      wr = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 4);
      a  = 10'($urandom);
      f  = {wr, 3'(nb - 1), 2'b00, a, 48'h0};
      exp_rx = '0;
      for (int k = 0; k < nb; k++) begin
        db = 8'($urandom);
        f[47-8*k -: 8] = db;
        exp_q.push_back(wr ? {1'b1, a, db} : {1'b0, a, 8'h00});
        exp_rx = {exp_rx[55:0], mem[a]};
        a = a - 10'd1;
      end
      send_frame(f, 16 + 8 * nb, -1, 1);
      if (!wr) chk($sformatf("b2b%0d_sdo", fr), rx_bits, exp_rx);
    end
    repeat (10) @(negedge clk);
    chk("b2b_n_ev", 64'(d_log.size()), 64'(exp_q.size()));
    rxp = (d_log.size() < exp_q.size()) ? d_log.size() : exp_q.size();
    for (int k = 0; k < rxp; k++) chk($sformatf("b2b_ev%0d", k), 64'(d_log[k]), 64'(exp_q[k]));
    chk("b2b_done", 64'(d_done_cnt - d0), 64'd20);
    chk("b2b_err", 64'(d_err_cnt - e0), 64'd0);
    chk("wr_rd_overlap", 64'(overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
